// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and its decoder:
// opcode values, sequencer state encoding and phase-bit positions.
package cpu_sequencer_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC1 = 3'd2,
        S_EXEC2 = 3'd3,
        S_HALT  = 3'd4
    } seq_state_e;

    // Defined opcodes; every other value is illegal
    localparam logic [3:0] OP_LDI = 4'b0000;
    localparam logic [3:0] OP_STA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_STP = 4'b0100;
    localparam logic [3:0] OP_LDA = 4'b0101;
    localparam logic [3:0] OP_JMS = 4'b0110;
    localparam logic [3:0] OP_BBL = 4'b0111;
    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_JEQ = 4'b1110;

    // Bit positions of the one-hot phase vector seen by the decoder
    localparam int PH_FETCH = 0;
    localparam int PH_EXEC1 = 1;
    localparam int PH_EXEC2 = 2;

endpackage

// File: rtl/cpu_sequencer_opcode_class.sv
// Combinational opcode classifier: how long an instruction executes,
// whether it stops the machine, and whether it is undefined.
module opcode_class
    import cpu_sequencer_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       two_cycle,
    output logic       stop,
    output logic       illegal
);

    // Decode the opcode into its execution class
    always_comb begin
        two_cycle = 1'b0;
        stop      = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_LDA, OP_ADD, OP_LDR:                          two_cycle = 1'b1;
            OP_STP:                                          stop      = 1'b1;
            OP_LDI, OP_STA, OP_JMP, OP_JMS, OP_BBL, OP_JEQ:  ;
            default:                                         illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: fetches one program word at a time, steps it
// through one or two execute phases, counts retired instructions and
// parks in HALT on STP or an undefined opcode until resumed.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int RET_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic             resume,
    input  logic [7:0]       prog_data,
    input  logic             prog_ready,
    output logic [2:0]       state,
    output logic [3:0]       inst,
    output logic [3:0]       operand,
    output logic             halted,
    output logic             illegal,
    output logic [RET_W-1:0] retired
);

    seq_state_e cur_st, nxt_st;
    logic       latch_word;
    logic       retire;
    logic       op_two_cycle;
    logic       op_stop;
    logic       op_illegal;

    opcode_class u_opcode_class (
        .opcode    (inst),
        .two_cycle (op_two_cycle),
        .stop      (op_stop),
        .illegal   (op_illegal)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_st <= S_IDLE;
        else        cur_st <= nxt_st;
    end

    // Next-state logic; step only matters from IDLE, resume only from HALT
    always_comb begin
        nxt_st     = cur_st;
        latch_word = 1'b0;
        retire     = 1'b0;
        case (cur_st)
            S_IDLE: begin
                if (run || step) nxt_st = S_FETCH;
            end
            S_FETCH: begin
                if (prog_ready) begin
                    latch_word = 1'b1;
                    nxt_st     = S_EXEC1;
                end
            end
            S_EXEC1: begin
                if (op_illegal) begin
                    nxt_st = S_HALT;
                end else if (op_two_cycle) begin
                    nxt_st = S_EXEC2;
                end else begin
                    retire = 1'b1;
                    // STP wins over run
                    if (op_stop)  nxt_st = S_HALT;
                    else if (run) nxt_st = S_FETCH;
                    else          nxt_st = S_IDLE;
                end
            end
            S_EXEC2: begin
                retire = 1'b1;
                nxt_st = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                if (resume) nxt_st = S_IDLE;
            end
            default: nxt_st = S_IDLE;
        endcase
    end

    // Instruction word is captured only when a fetch completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst    <= 4'd0;
            operand <= 4'd0;
        end else if (latch_word) begin
            inst    <= prog_data[7:4];
            operand <= prog_data[3:0];
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      retired <= '0;
        else if (retire) retired <= retired + RET_W'(1);
    end

    // Decoder-facing outputs derived from the current state
    always_comb begin
        state           = 3'b000;
        state[PH_FETCH] = (cur_st == S_FETCH);
        state[PH_EXEC1] = (cur_st == S_EXEC1);
        state[PH_EXEC2] = (cur_st == S_EXEC2);
        halted          = (cur_st == S_HALT);
        illegal         = (cur_st == S_EXEC1) && op_illegal;
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed vector table, hand
// sequences for wait states / async reset / counter wrap, then random
// stimulus against an instruction-level reference model.
module tb_cpu_sequencer;

    localparam int SMALL_W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run, step, resume, prog_ready;
    logic [7:0]  prog_data;
    logic [2:0]  state;
    logic [3:0]  inst, operand;
    logic        halted, illegal;
    logic [15:0] retired;
    logic [2:0]  s_state;
    logic [3:0]  s_inst, s_operand;
    logic        s_halted, s_illegal;
    logic [SMALL_W-1:0] s_retired;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpu_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .resume(resume),
        .prog_data(prog_data), .prog_ready(prog_ready),
        .state(state), .inst(inst), .operand(operand),
        .halted(halted), .illegal(illegal), .retired(retired)
    );

    // Narrow-counter copy so the wrap boundary is reachable quickly
    cpu_sequencer #(.RET_W(SMALL_W)) u_small (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .resume(resume),
        .prog_data(prog_data), .prog_ready(prog_ready),
        .state(s_state), .inst(s_inst), .operand(s_operand),
        .halted(s_halted), .illegal(s_illegal), .retired(s_retired)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (instruction level) ----------------
    // Execute length per opcode: 0 = undefined, else 1 or 2 exec cycles
    int len_tbl [16] = '{1, 1, 2, 1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 2, 1, 0};
    int          m_ph;   // 0 idle, 1 fetching, 2 executing, 3 halted
    int          m_k;    // exec cycles already spent on current instruction
    logic [3:0]  m_ins, m_opd;
    logic [31:0] m_cnt;

    task automatic model_reset();
        m_ph = 0; m_k = 0; m_ins = 4'd0; m_opd = 4'd0; m_cnt = 0;
    endtask

    task automatic model_step();
        int len;
        len = len_tbl[m_ins];
        case (m_ph)
            0: if (run || step) m_ph = 1;
            1: if (prog_ready) begin
                   m_ins = prog_data[7:4]; m_opd = prog_data[3:0];
                   m_ph = 2; m_k = 0;
               end
            2: if (len == 0) m_ph = 3;
               else if (m_k + 1 < len) m_k++;
               else begin
                   m_cnt = m_cnt + 1;
                   m_ph  = (m_ins == 4'd4) ? 3 : (run ? 1 : 0);
               end
            default: if (resume) m_ph = 0;
        endcase
    endtask

    task automatic check_model(input string tag);
        logic [2:0] est;
        logic       eill;
        est  = (m_ph == 1) ? 3'b001 : (m_ph == 2) ? ((m_k == 0) ? 3'b010 : 3'b100) : 3'b000;
        eill = (m_ph == 2) && (m_k == 0) && (len_tbl[m_ins] == 0);
        chk({tag, ".state"},   {29'd0, state},     {29'd0, est});
        chk({tag, ".inst"},    {28'd0, inst},      {28'd0, m_ins});
        chk({tag, ".operand"}, {28'd0, operand},   {28'd0, m_opd});
        chk({tag, ".halted"},  {31'd0, halted},    {31'd0, m_ph == 3});
        chk({tag, ".illegal"}, {31'd0, illegal},   {31'd0, eill});
        chk({tag, ".retired"}, {16'd0, retired},   {16'd0, m_cnt[15:0]});
        chk({tag, ".s_retired"}, {24'd0, s_retired}, {24'd0, m_cnt[SMALL_W-1:0]});
    endtask

    // One clock: model consumes the inputs sampled at this edge
    task automatic tick();
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic rs,
                         input logic rdy, input logic [7:0] d);
        run = r; step = s; resume = rs; prog_ready = rdy; prog_data = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       run, step, resume, rdy;
        logic [7:0] data;
        logic [2:0] st;
        logic [3:0] ins, opd;
        logic       hlt, ill;
        logic [15:0] ret;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic s, input logic rs, input logic rdy,
                                input logic [7:0] d, input logic [2:0] st, input logic [3:0] ins,
                                input logic [3:0] opd, input logic hlt, input logic ill,
                                input logic [15:0] ret);
        vec_t v;
        v.run = r; v.step = s; v.resume = rs; v.rdy = rdy; v.data = d;
        v.st = st; v.ins = ins; v.opd = opd; v.hlt = hlt; v.ill = ill; v.ret = ret;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 8'h00);
        model_reset();

        // Reset values hold before any clock edge
        #3;
        chk("rst.state",   {29'd0, state},   32'd0);
        chk("rst.inst",    {28'd0, inst},    32'd0);
        chk("rst.operand", {28'd0, operand}, 32'd0);
        chk("rst.halted",  {31'd0, halted},  32'd0);
        chk("rst.illegal", {31'd0, illegal}, 32'd0);
        chk("rst.retired", {16'd0, retired}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        //          run stp res rdy data   state   ins   opd  hlt ill ret
        tbl.push_back(mk(1, 0, 0, 1, 8'h53, 3'b001, 4'h0, 4'h0, 0, 0, 16'd0)); // LDA 3
        tbl.push_back(mk(1, 0, 0, 1, 8'h53, 3'b010, 4'h5, 4'h3, 0, 0, 16'd0));
        tbl.push_back(mk(1, 0, 0, 1, 8'h53, 3'b100, 4'h5, 4'h3, 0, 0, 16'd0));
        tbl.push_back(mk(1, 0, 0, 1, 8'h53, 3'b001, 4'h5, 4'h3, 0, 0, 16'd1));
        tbl.push_back(mk(0, 0, 0, 1, 8'h07, 3'b010, 4'h0, 4'h7, 0, 0, 16'd1)); // run falls
        tbl.push_back(mk(0, 0, 0, 1, 8'h07, 3'b000, 4'h0, 4'h7, 0, 0, 16'd2));
        tbl.push_back(mk(0, 1, 0, 1, 8'h21, 3'b001, 4'h0, 4'h7, 0, 0, 16'd2)); // step ADD
        tbl.push_back(mk(0, 0, 0, 1, 8'h21, 3'b010, 4'h2, 4'h1, 0, 0, 16'd2));
        tbl.push_back(mk(0, 1, 0, 1, 8'h21, 3'b100, 4'h2, 4'h1, 0, 0, 16'd2)); // step ignored
        tbl.push_back(mk(0, 0, 0, 1, 8'h21, 3'b000, 4'h2, 4'h1, 0, 0, 16'd3));
        tbl.push_back(mk(0, 0, 0, 1, 8'h21, 3'b000, 4'h2, 4'h1, 0, 0, 16'd3));
        tbl.push_back(mk(1, 0, 0, 1, 8'h40, 3'b001, 4'h2, 4'h1, 0, 0, 16'd3)); // STP
        tbl.push_back(mk(1, 0, 0, 1, 8'h40, 3'b010, 4'h4, 4'h0, 0, 0, 16'd3));
        tbl.push_back(mk(1, 0, 0, 1, 8'h40, 3'b000, 4'h4, 4'h0, 1, 0, 16'd4));
        tbl.push_back(mk(1, 1, 0, 1, 8'h40, 3'b000, 4'h4, 4'h0, 1, 0, 16'd4)); // run/step ignored
        tbl.push_back(mk(1, 0, 1, 1, 8'h40, 3'b000, 4'h4, 4'h0, 0, 0, 16'd4)); // resume
        tbl.push_back(mk(1, 0, 0, 1, 8'hF0, 3'b001, 4'h4, 4'h0, 0, 0, 16'd4));
        tbl.push_back(mk(1, 0, 0, 1, 8'hF0, 3'b010, 4'hF, 4'h0, 0, 1, 16'd4)); // illegal
        tbl.push_back(mk(1, 0, 0, 1, 8'hF0, 3'b000, 4'hF, 4'h0, 1, 0, 16'd4));
        tbl.push_back(mk(0, 0, 1, 1, 8'hF0, 3'b000, 4'hF, 4'h0, 0, 0, 16'd4));
        tbl.push_back(mk(0, 0, 1, 1, 8'hF0, 3'b000, 4'hF, 4'h0, 0, 0, 16'd4)); // resume in IDLE

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(tbl[i].run, tbl[i].step, tbl[i].resume, tbl[i].rdy, tbl[i].data);
            tick();
            chk({tag, ".state"},   {29'd0, state},   {29'd0, tbl[i].st});
            chk({tag, ".inst"},    {28'd0, inst},    {28'd0, tbl[i].ins});
            chk({tag, ".operand"}, {28'd0, operand}, {28'd0, tbl[i].opd});
            chk({tag, ".halted"},  {31'd0, halted},  {31'd0, tbl[i].hlt});
            chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, tbl[i].ill});
            chk({tag, ".retired"}, {16'd0, retired}, {16'd0, tbl[i].ret});
        end

        // Fetch wait states: FETCH visible for 4 cycles, then LDI 7
        drive(1, 0, 0, 0, 8'h07);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("wait%0d.state", c), {29'd0, state}, 32'd1);
        end
        prog_ready = 1'b1;
        tick();
        chk("wait.exec1", {29'd0, state}, 32'd2);
        chk("wait.inst",  {28'd0, inst},  32'd0);
        chk("wait.opd",   {28'd0, operand}, 32'd7);
        run = 1'b0;
        tick();
        chk("wait.retired", {16'd0, retired}, 32'd5);
        check_model("wait.model");

        // Asynchronous reset in EXEC2 abandons the instruction
        drive(1, 0, 0, 1, 8'h53);
        tick(); tick(); tick();
        chk("arst.pre", {29'd0, state}, 32'd4);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst.state",   {29'd0, state},   32'd0);
        chk("arst.retired", {16'd0, retired}, 32'd0);
        chk("arst.inst",    {28'd0, inst},    32'd0);
        @(posedge clk); #1;
        chk("arst.hold", {29'd0, state}, 32'd0);
        rst_n = 1'b1;
        tick();
        check_model("arst.first");

        // Counter wrap on the narrow copy
        do_reset();
        drive(1, 0, 0, 1, 8'h0A);
        tick();
        for (int n = 0; n < (1 << SMALL_W) - 1; n++) begin
            tick(); tick();
        end
        chk("wrap.full",  {24'd0, s_retired}, (32'd1 << SMALL_W) - 1);
        chk("wrap.wide",  {16'd0, retired},   (32'd1 << SMALL_W) - 1);
        tick(); tick();
        chk("wrap.zero",  {24'd0, s_retired}, 32'd0);
        chk("wrap.wide2", {16'd0, retired},   32'd1 << SMALL_W);
        run = 1'b0;
        tick(); tick();
        check_model("wrap.end");

        // Random stimulus against the model, with occasional async resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) run = ~run;
            step       = ($urandom_range(5) == 0);
            resume     = ($urandom_range(7) == 0);
            prog_ready = ($urandom_range(3) != 0);
            prog_data  = 8'($urandom);
            tick();
            check_model($sformatf("rnd%0d", c));
            if ($urandom_range(199) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #2;
                check_model($sformatf("rnd%0d.rst", c));
                rst_n = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter RET_W, default 16, the width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port run, input, 1, level; free-running execution enable.
REQ-005 SHALL have port step, input, 1, single-cycle pulse; execute exactly one instruction while run=0.
REQ-006 SHALL have port resume, input, 1, single-cycle pulse; leave HALT.
REQ-007 SHALL have port prog_data, input, 8; program-memory word, where [7:4] is the opcode and [3:0] the operand.
REQ-008 SHALL have port prog_ready, input, 1; prog_data is valid this cycle.
REQ-009 SHALL have port state, output, 3; one-hot phase to the decoder: bit0 fetch, bit1 exec1, bit2 exec2.
REQ-010 SHALL have port inst, output, 4; latched opcode.
REQ-011 SHALL have port operand, output, 4; latched operand.
REQ-012 SHALL have port halted, output, 1; high while in HALT.
REQ-013 SHALL have port illegal, output, 1; one-cycle pulse when an undefined opcode executes.
REQ-014 SHALL have port retired, output, RET_W; count of completed instructions.

Function
REQ-015 SHALL implement the states IDLE, FETCH, EXEC1, EXEC2 and HALT; state output is 000 in IDLE and HALT, 001 in FETCH, 010 in EXEC1, 100 in EXEC2.
REQ-016 SHALL move IDLE->FETCH when run=1, or when step=1 and run=0; otherwise it stays in IDLE.
REQ-017 SHALL hold FETCH while prog_ready=0 (wait states unbounded); with prog_ready=1 it latches prog_data into inst and operand, then moves to EXEC1.
REQ-018 SHALL hold inst and operand stable from the EXEC1 entry until the next FETCH completes.
REQ-019 SHALL classify opcodes LDI 0000, STA 0001, ADD 0010, JMP 0011, STP 0100, LDA 0101, JMS 0110, BBL 0111, LDR 1101 and JEQ 1110 as defined; all others are illegal.
REQ-020 SHALL move EXEC1->EXEC2 for LDA, ADD and LDR.
REQ-021 SHALL move EXEC1->HALT for STP.
REQ-022 SHALL, in EXEC1 with an illegal opcode, pulse illegal for that cycle and move to HALT; the retired count is not incremented.
REQ-023 SHALL, from the final exec cycle of any other instruction, go to FETCH if run=1, else to IDLE.
REQ-024 SHALL increment retired in the final exec cycle of each legal instruction, STP included; it wraps from 2^RET_W-1 to 0.
REQ-025 SHALL let an instruction in flight complete when run falls mid-instruction, then go to IDLE.
REQ-026 SHALL ignore step outside IDLE and whenever run=1.
REQ-027 SHALL move HALT->IDLE on resume=1 and ignore run and step while in HALT; resume outside HALT has no effect.
REQ-028 SHALL give HALT priority over run when STP completes with run=1.

Reset
REQ-029 SHALL, while rst_n=0, force the IDLE state, state=000, inst=0000, operand=0000, halted=0, illegal=0 and retired=0, regardless of clk.
REQ-030 SHALL abandon any in-flight instruction on reset without incrementing retired.
REQ-031 SHALL first sample run and step on the first rising edge of clk after rst_n deasserts.

Structure
REQ-032 SHALL place the opcode constants, the state encoding and the phase bit positions in a shared package used with the decoder.
REQ-033 SHALL use one sub-module, opcode_class: combinational, opcode in, two_cycle/stop/illegal flags out.

Verification
REQ-034 SHALL cover: reset; run=1; program 0x53 (LDA 3), prog_ready always 1 -> state 001,010,100,001; retired=1 after the EXEC2 cycle.
REQ-035 SHALL cover: run=1; FETCH with prog_ready=0 for 3 cycles, then 0x07 -> state 001 held for 4 cycles; inst=0000 and operand=7 in EXEC1.
REQ-036 SHALL cover: run=0; one step pulse; word 0x21 -> exactly FETCH, EXEC1, EXEC2, then IDLE; retired=1; a second step issued during EXEC1 is ignored.
REQ-037 SHALL cover: run=1; word 0x40 (STP) -> halted=1 the cycle after EXEC1 with retired incremented; run stays ignored; resume -> IDLE, then FETCH.
REQ-038 SHALL cover: word 0xF0 -> illegal pulses for exactly 1 cycle in EXEC1, then HALT, retired unchanged.
REQ-039 SHALL cover: retired preset near 0xFFFF via 0xFFFF legal instructions, then one more -> 0x0000; rst_n low during EXEC2 -> state=000 asynchronously.
